// File: rtl/voice_slot_scheduler.sv
// voice_slot_scheduler
//   Time-shares one pwm_sample divider input among NUM_VOICES voices,
//   one voice per clock, round-robin. Holds per-voice divider/enable/
//   duration configuration, runs the play/pause/stop sequencer and the
//   beat timebase, and issues staggered per-voice note-advance pulses.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   start, stop, pause            sequencer controls (levels, stop > start > pause)
//   cfg_valid/cfg_ready           config write handshake
//   cfg_voice/divider/enable/dur  config write payload
//   slot_idx, slot_divider        voice owning this output slot and its divider
//   slot_valid                    output slot is live (RUN only)
//   note_adv                      one-cycle advance pulse per voice
//   beat_count                    beats elapsed since start, wraps
//   running                       sequencer is in RUN
//
// state | meaning
// IDLE  | stopped, beat timebase cleared, slots output 0
// RUN   | playing, beat timebase counting, slots live
// HOLD  | paused, beat timebase frozen, slots output 0
module voice_slot_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SLOT_W     = 2,
  parameter int DIV_W      = 11,
  parameter int BEAT_W     = 22,
  parameter int BCNT_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SLOT_W-1:0]     cfg_voice,
  input  logic [DIV_W-1:0]      cfg_divider,
  input  logic                  cfg_enable,
  input  logic [BCNT_W-1:0]     cfg_dur,
  output logic [SLOT_W-1:0]     slot_idx,
  output logic [DIV_W-1:0]      slot_divider,
  output logic                  slot_valid,
  output logic [NUM_VOICES-1:0] note_adv,
  output logic [BCNT_W-1:0]     beat_count,
  output logic                  running
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
  logic [BEAT_W-1:0]       beat_phase_q, beat_phase_d;
  logic [BCNT_W-1:0]       beat_count_q, beat_count_d;

  logic [DIV_W-1:0]        div_q [NUM_VOICES];
  logic [DIV_W-1:0]        div_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en_q, en_d;
  logic [BCNT_W-1:0]       dur_q [NUM_VOICES];
  logic [BCNT_W-1:0]       dur_d [NUM_VOICES];

  logic                    pend_q, pend_d;
  logic [SLOT_W-1:0]       pend_voice_q, pend_voice_d;
  logic [DIV_W-1:0]        pend_div_q, pend_div_d;
  logic                    pend_en_q, pend_en_d;
  logic [BCNT_W-1:0]       pend_dur_q, pend_dur_d;

  logic [SLOT_W-1:0]       slot_idx_q, slot_idx_d;
  logic [DIV_W-1:0]        slot_divider_q, slot_divider_d;
  logic                    slot_valid_q, slot_valid_d;
  logic [NUM_VOICES-1:0]   note_adv_q, note_adv_d;

  logic                    commit;
  logic                    accept;

  assign commit = pend_q && (pend_voice_q == slot_cnt_q);
  assign accept = cfg_valid && !pend_q;

  // Voice registers. The *_d view already contains a committing write, so
  // the slot output of the commit edge sees the new value directly.
  always_comb begin
    div_d = div_q;
    en_d  = en_q;
    dur_d = dur_q;
    if (commit) begin
      div_d[pend_voice_q] = pend_div_q;
      en_d[pend_voice_q]  = pend_en_q;
      dur_d[pend_voice_q] = pend_dur_q;
    end
  end

  always_comb begin
    pend_d       = pend_q;
    pend_voice_d = pend_voice_q;
    pend_div_d   = pend_div_q;
    pend_en_d    = pend_en_q;
    pend_dur_d   = pend_dur_q;
    if (commit) pend_d = 1'b0;
    // accept and commit are exclusive: accept requires an empty buffer.
    if (accept) begin
      pend_d       = 1'b1;
      pend_voice_d = cfg_voice;
      pend_div_d   = cfg_divider;
      pend_en_d    = cfg_enable;
      pend_dur_d   = cfg_dur;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_phase_d = beat_phase_q;
    beat_count_d = beat_count_q;
    case (state_q)
      ST_IDLE: begin
        beat_phase_d = '0;
        if (!stop && start) begin
          state_d      = ST_RUN;
          beat_count_d = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d      = ST_IDLE;
          beat_phase_d = '0;
        end else begin
          if (pause) state_d = ST_HOLD;
          beat_phase_d = beat_phase_q + BEAT_W'(1);
          if (&beat_phase_q) beat_count_d = beat_count_q + BCNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d      = ST_IDLE;
          beat_phase_d = '0;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        beat_phase_d = '0;
      end
    endcase
  end

  // Advance phases are i+1 so each voice pulses in its own cycle of the beat.
  always_comb begin
    slot_cnt_d     = slot_cnt_q + SLOT_W'(1);
    slot_idx_d     = slot_cnt_q;
    slot_valid_d   = (state_q == ST_RUN);
    slot_divider_d = ((state_q == ST_RUN) && en_d[slot_cnt_q]) ? div_d[slot_cnt_q] : '0;
    note_adv_d     = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_adv_d[i] = (state_q == ST_RUN) &&
                      (beat_phase_q == BEAT_W'(i + 1)) &&
                      ((beat_count_q & dur_d[i]) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      slot_cnt_q     <= '0;
      beat_phase_q   <= '0;
      beat_count_q   <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        div_q[i] <= '0;
        dur_q[i] <= '0;
      end
      en_q           <= '0;
      pend_q         <= 1'b0;
      pend_voice_q   <= '0;
      pend_div_q     <= '0;
      pend_en_q      <= 1'b0;
      pend_dur_q     <= '0;
      slot_idx_q     <= '0;
      slot_divider_q <= '0;
      slot_valid_q   <= 1'b0;
      note_adv_q     <= '0;
    end else begin
      state_q        <= state_d;
      slot_cnt_q     <= slot_cnt_d;
      beat_phase_q   <= beat_phase_d;
      beat_count_q   <= beat_count_d;
      div_q          <= div_d;
      dur_q          <= dur_d;
      en_q           <= en_d;
      pend_q         <= pend_d;
      pend_voice_q   <= pend_voice_d;
      pend_div_q     <= pend_div_d;
      pend_en_q      <= pend_en_d;
      pend_dur_q     <= pend_dur_d;
      slot_idx_q     <= slot_idx_d;
      slot_divider_q <= slot_divider_d;
      slot_valid_q   <= slot_valid_d;
      note_adv_q     <= note_adv_d;
    end
  end

  assign cfg_ready    = !pend_q;
  assign slot_idx     = slot_idx_q;
  assign slot_divider = slot_divider_q;
  assign slot_valid   = slot_valid_q;
  assign note_adv     = note_adv_q;
  assign beat_count   = beat_count_q;
  assign running      = (state_q == ST_RUN);

endmodule

// File: tb/tb_voice_slot_scheduler.sv
// Scoreboard bench for voice_slot_scheduler (built with a 16-clock beat).
module tb_voice_slot_scheduler;

  localparam int NV = 4;
  localparam int BW = 4;
  localparam int PHASES = 16;
  localparam int BEATS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 0, stop = 0, pause = 0;
  logic        cfg_valid = 0, cfg_enable = 0;
  logic        cfg_ready;
  logic [1:0]  cfg_voice = 0;
  logic [10:0] cfg_divider = 0;
  logic [2:0]  cfg_dur = 0;
  logic [1:0]  slot_idx;
  logic [10:0] slot_divider;
  logic        slot_valid;
  logic [3:0]  note_adv;
  logic [2:0]  beat_count;
  logic        running;

  voice_slot_scheduler #(.NUM_VOICES(NV), .SLOT_W(2), .DIV_W(11), .BEAT_W(BW), .BCNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
    .cfg_divider(cfg_divider), .cfg_enable(cfg_enable), .cfg_dur(cfg_dur),
    .slot_idx(slot_idx), .slot_divider(slot_divider), .slot_valid(slot_valid),
    .note_adv(note_adv), .beat_count(beat_count), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx; int dv; int vl; int adv; int bc; int run; int rdy;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: 0 = stopped, 1 = playing, 2 = paused
  int m_div[NV], m_en[NV], m_dur[NV];
  int m_slot, m_mode, m_phase, m_beats;
  int m_pend, m_pv, m_pd, m_pe, m_pdur;

  function automatic exp_t reset_record();
    exp_t e;
    e.idx = 0; e.dv = 0; e.vl = 0; e.adv = 0; e.bc = 0; e.run = 0; e.rdy = 1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin m_div[i] = 0; m_en[i] = 0; m_dur[i] = 0; end
    m_slot = 0; m_mode = 0; m_phase = 0; m_beats = 0;
    m_pend = 0; m_pv = 0; m_pd = 0; m_pe = 0; m_pdur = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int ediv[NV], een[NV], edur[NV];
    int c, acc, nm;
    for (int i = 0; i < NV; i++) begin ediv[i] = m_div[i]; een[i] = m_en[i]; edur[i] = m_dur[i]; end
    c = (m_pend != 0) && (m_pv == m_slot);
    if (c) begin ediv[m_pv] = m_pd; een[m_pv] = m_pe; edur[m_pv] = m_pdur; end
    e.idx = m_slot;
    e.dv  = (m_mode == 1 && een[m_slot] != 0) ? ediv[m_slot] : 0;
    e.vl  = (m_mode == 1);
    e.adv = 0;
    for (int i = 0; i < NV; i++)
      if (m_mode == 1 && m_phase == i + 1 && (m_beats & edur[i]) == 0) e.adv += (1 << i);
    acc = cfg_valid && (m_pend == 0);
    if (c) begin
      for (int i = 0; i < NV; i++) begin m_div[i] = ediv[i]; m_en[i] = een[i]; m_dur[i] = edur[i]; end
      m_pend = 0;
    end
    if (acc) begin
      m_pend = 1; m_pv = cfg_voice; m_pd = cfg_divider; m_pe = cfg_enable; m_pdur = cfg_dur;
    end
    nm = m_mode;
    if (stop) nm = 0;
    else if (m_mode == 0 && start) nm = 1;
    else if (m_mode == 1 && pause) nm = 2;
    else if (m_mode == 2 && !pause) nm = 1;
    if (m_mode == 1 && nm != 0) begin
      m_phase = (m_phase + 1) % PHASES;
      if (m_phase == 0) m_beats = (m_beats + 1) % BEATS;
    end
    if (m_mode == 0 && nm == 1) begin m_phase = 0; m_beats = 0; end
    if (nm == 0) m_phase = 0;
    m_mode = nm;
    m_slot = (m_slot + 1) % NV;
    e.bc  = m_beats;
    e.run = (m_mode == 1);
    e.rdy = (m_pend == 0);
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.push_back(reset_record());
      end else begin
        model_step();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input int want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, want);
    end
  endtask

  // Monitor: every edge (or reset assertion) presents a new output vector.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty at %0t: got no expected entry, expected one", $time);
      end else begin
        e = exp_q.pop_front();
        vectors++;
        chk("slot_idx",     32'(slot_idx),     e.idx);
        chk("slot_divider", 32'(slot_divider), e.dv);
        chk("slot_valid",   32'(slot_valid),   e.vl);
        chk("note_adv",     32'(note_adv),     e.adv);
        chk("beat_count",   32'(beat_count),   e.bc);
        chk("running",      32'(running),      e.run);
        chk("cfg_ready",    32'(cfg_ready),    e.rdy);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      miscompares++;
      $display("FAIL cfg_ready_wait at %0t: got ready=0 for 40 cycles, expected 1", $time);
    end
  endtask

  task automatic cfg_write(input int v, input int d, input int en, input int du);
    wait_ready();
    cfg_valid = 1; cfg_voice = 2'(v); cfg_divider = 11'(d); cfg_enable = en[0]; cfg_dur = 3'(du);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  initial begin
    int n;
    #1 rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(2);

    cfg_write(0, 956, 1, 0);
    cfg_write(1, 318, 1, 1);
    cfg_write(2, 252, 1, 3);
    cfg_write(3, 212, 1, 7);
    wait_ready();
    tick(1);
    start = 1; tick(1); start = 0;
    tick(8 * PHASES + 6);

    // Write voice 2 so that it is accepted while the slot counter is 2.
    n = 0;
    while (!(m_slot == 2 && cfg_ready) && n < 20) begin tick(1); n++; end
    cfg_write(2, 477, 1, 3);
    tick(8);

    pause = 1; tick(37); pause = 0;
    tick(3 * PHASES);

    start = 1; stop = 1; tick(1); start = 0; stop = 0;
    tick(5);
    start = 1; tick(1); start = 0;
    tick(PHASES + 4);

    // Reset pulse between edges while a write is pending.
    cfg_write(1, 999, 1, 0);
    #2 rst_n = 0;
    #2 rst_n = 1;
    @(negedge clk);
    tick(6);
    start = 1; tick(1); start = 0;
    tick(10);

    for (int k = 0; k < 700; k++) begin
      start     = ($urandom_range(0, 19) == 0);
      stop      = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 29) == 0) pause = ~pause;
      cfg_valid   = ($urandom_range(0, 5) == 0);
      cfg_voice   = 2'($urandom_range(0, 3));
      cfg_divider = 11'($urandom_range(0, 2047));
      cfg_enable  = ($urandom_range(0, 3) != 0);
      cfg_dur     = 3'($urandom_range(0, 7));
      tick(1);
    end
    start = 0; stop = 0; pause = 0; cfg_valid = 0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_slot_scheduler.md
Name: voice_slot_scheduler

Overview:
- Time-shares the single pwm_sample divider input among NUM_VOICES voices (slot 0 cello, slots 1..3 violins), one voice per clock, round-robin.
- Holds the per-voice divider, enable and duration configuration, loaded through a valid/ready port. Each write commits only at that voice's slot boundary, so a slot never sees a half-updated value.
- Contains the play/pause/stop sequencer and the beat timebase. Issues staggered per-voice note-advance pulses to the note-index logic.

Parameters:
- NUM_VOICES, 4, number of time slots; power of 2, at least 2.
- SLOT_W, 2, log2(NUM_VOICES).
- DIV_W, 11, divider width.
- BEAT_W, 22, beat period is 2^BEAT_W clocks.
- BCNT_W, 3, beat counter width; also the duration mask width.

Ports:
- clk  in  1  project clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  level; IDLE->RUN
- stop  in  1  level; any state->IDLE
- pause  in  1  level; RUN<->HOLD
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid&&cfg_ready
- cfg_voice  in  SLOT_W  target voice
- cfg_divider  in  DIV_W  divider for voice
- cfg_enable  in  1  voice unmuted
- cfg_dur  in  BCNT_W  duration mask for voice
- slot_idx  out  SLOT_W  voice owning current output slot
- slot_divider  out  DIV_W  divider for pwm_sample this cycle
- slot_valid  out  1  high in RUN only
- note_adv  out  NUM_VOICES  one-cycle advance pulse per voice
- beat_count  out  BCNT_W  beats elapsed since start, wraps
- running  out  1  state==RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE; all dividers, enables and durs 0; slot counter 0; beat_phase 0; beat_count 0; no write pending; cfg_ready=1; slot_idx=0; slot_divider=0; slot_valid=0; note_adv=0; running=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. A pending write is dropped.
- Slot counter: free-running in every state, +1 per clock, wraps NUM_VOICES-1 -> 0.
- Outputs are registered. On each edge: slot_idx <= slot counter; slot_divider <= (state==RUN && en[slot counter]) ? div[slot counter] : 0; slot_valid <= (state==RUN). Latency from slot counter to output is 1 cycle.
- FSM priority is stop > start > pause.
  - IDLE: start -> RUN; beat_phase and beat_count cleared to 0.
  - RUN: stop -> IDLE; else pause -> HOLD.
  - HOLD: stop -> IDLE; else !pause -> RUN.
  - start while in RUN or HOLD is ignored.
- beat_phase (BEAT_W bits):
  - increments only in RUN;
  - frozen in HOLD;
  - held at 0 in IDLE.
  - When it wraps from all-ones to 0, beat_count increments (mod 2^BCNT_W).
- note_adv[i] is high for one cycle when all of the following hold: state==RUN, beat_phase==i+1 (staggered, so voices never advance in the same cycle), and (beat_count & dur[i])==0. Result:
  - dur=0 advances every beat;
  - dur=1 every 2 beats;
  - dur=3 every 4 beats;
  - dur=7 every 8 beats.
- note_adv is registered and is 0 in IDLE and HOLD. Pulses do not depend on en[i].
- Config handshake:
  - On accept, voice/divider/enable/dur are captured into a pending buffer and cfg_ready drops the next cycle.
  - Commit: on the first edge where slot counter == pending voice, the buffer is copied into voice registers. That same edge presents the new value on slot_divider, if RUN and enabled.
  - cfg_ready returns to 1 the cycle after commit.
  - Accept-to-commit latency is 1..NUM_VOICES cycles.
  - At most one write is pending; cfg_valid while cfg_ready=0 is ignored.
  - A write targeting the voice whose slot is in the acceptance cycle commits on its next slot, NUM_VOICES cycles later, not the same cycle.
- A write in any state updates configuration. Writing a voice changes that voice's note_adv gating from the commit cycle onward.
- stop during a pending write: the write still commits; the state change does not cancel it.

Test Plan:
- Reset release, cfg writes div[0..3]=956,318,252,212 all enabled, start -> slot_divider cycles 956,318,252,212 with slot_idx 0,1,2,3; slot_valid=1.
- In RUN, write voice 2 divider=477 accepted when slot counter=2 -> cfg_ready low 4 cycles; 477 first appears at slot_idx=2 exactly NUM_VOICES cycles later; no intermediate value.
- BEAT_W=4 build, dur=0,1,3,7 -> over 8 beats note_adv[0..3] pulse 8,4,2,1 times at phases 1,2,3,4.
- pause for 37 cycles then release -> slot_divider=0 and slot_valid=0 during HOLD; beat_phase/beat_count resume from frozen values; no note_adv lost or duplicated.
- start and stop asserted together in RUN -> IDLE; slot_divider=0 next cycle; next start clears beat_count to 0.
- rst_n pulsed low between edges mid-write -> all outputs 0 and cfg_ready=1 before the next edge; the pending write never commits.
